decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined, handshaked RV32-style instruction decode stage.
- Sits between fetch and register-read/execute.
- Accepts {inst, pc} on a valid/ready interface and emits a registered decoded bundle.
- Over a single-cycle decoder it adds: parametrised immediate width, register-index range checking for reduced register files, illegal-instruction flagging, a 2-entry skid buffer for full throughput under backpressure, and flush.

Parameters:
- XLEN, 8: width of the `imm` output.
- REG_ADDR_WIDTH, 4: register index width. Register fields use their low REG_ADDR_WIDTH bits.
- PC_WIDTH, 8: width of `pc` in/out.
- INST_WIDTH, 32: instruction width. Fixed at 32 and checked at elaboration.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept.
- inst  in  INST_WIDTH  instruction word.
- pc_in  in  PC_WIDTH  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- op  out  7  inst[6:0].
- rd  out  REG_ADDR_WIDTH  low bits of inst[11:7].
- rs1  out  REG_ADDR_WIDTH  low bits of inst[19:15].
- rs2  out  REG_ADDR_WIDTH  low bits of inst[24:20].
- funct3  out  3  inst[14:12].
- funct7  out  7  inst[31:25].
- imm  out  XLEN  selected immediate.
- imm_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 R.
- illegal  out  1  instruction not supported.
- pc_out  out  PC_WIDTH  pc_in of this bundle.

Behaviour:
- Decode is combinational on `inst`. Results are captured into the main register or the skid register on accept.
- All outputs come from the main register, so no combinational path runs from inst to outputs.
- Accept: `in_valid && in_ready` at posedge. Output transfer: `out_valid && out_ready` at posedge.
- `in_ready` is a function of state only, with no combinational path from `out_ready`: 1 in EMPTY and ONE, 0 in TWO.
- Format by opcode:
  - LUI 0110111, AUIPC 0010111: U.
  - JAL 1101111: J.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: I.
  - STORE 0100011: S.
  - BRANCH 1100011: B.
  - OP 0110011: R; imm=0.
  - Any other opcode: NONE; imm=0, illegal=1.
- Immediate construction:
  - Build the 32-bit RV32I immediate with sign extension from inst[31]. U has low 12 bits zero; B and J have bit0 zero.
  - If XLEN<32, imm is the low XLEN bits. If XLEN>32, sign-extend bit31.
- illegal is also set when:
  - inst[1:0]!=2'b11, or
  - any register field used by the format has a nonzero bit at or above REG_ADDR_WIDTH. Used fields: R→rd,rs1,rs2; I→rd,rs1; S/B→rs1,rs2; U/J→rd.
- Illegal instructions still flow through with all fields populated. The stage never drops them; the consumer traps.
- States:
  - EMPTY: out_valid=0.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Transitions:
  - EMPTY + accept → ONE, main←new.
  - ONE + accept + out_ready → ONE, main←new.
  - ONE + accept + !out_ready → TWO, skid←new.
  - ONE + !accept + out_ready → EMPTY.
  - TWO + out_ready → ONE, main←skid.
  - TWO + !out_ready → TWO, hold.
- Throughput and latency:
  - Throughput is 1/cycle when out_ready stays 1.
  - Latency from accept to out_valid is 1 cycle.
  - Ordering is strictly FIFO.
- Output stability: while out_valid=1 and out_ready=0, all outputs hold stable.
- flush (rst_n=1): next state EMPTY, out_valid=0, in_ready=1. Any same-cycle input is dropped. flush has priority over accept and transfer.
- Reset (rst_n=0 at posedge): state EMPTY and all output registers zeroed (op, rd, rs1, rs2, funct3, funct7, imm, imm_fmt, illegal, pc_out = 0). Resulting values: out_valid=0, in_ready=1. Reset mid-stream discards all contents and overrides flush.

Test Plan:
- XLEN=32, RAW=5. inst=0xFFF10093 (addi x1,x2,-1), in_valid one cycle, out_ready=1 → next cycle: out_valid=1, op=0x13, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, imm_fmt=1, illegal=0.
- XLEN=32. inst=0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, imm_fmt=3. Then inst=0x123450B7 (lui x1) → imm=0x12345000, imm_fmt=4. XLEN=8: the same lui gives imm=0x00.
- RAW=4. inst=0x00000893 (addi x17,x0,0) → illegal=1, rd=1, out_valid=1. inst=0x0000000B (opcode 0001011) → illegal=1, imm_fmt=0, imm=0.
- Backpressure: hold out_ready=0 and send A (pc 0x10), B (pc 0x14) back-to-back → state TWO and in_ready=0 after B. out_ready=1 → A then B on consecutive cycles, pc_out 0x10 then 0x14. in_ready returns to 1 the cycle after A transfers.
- In state TWO, assert flush with in_valid=1 → next cycle: out_valid=0, in_ready=1. Neither the held instructions nor the flushing-cycle instruction ever appears.
- Streaming 8 instructions with out_ready=1, then assert rst_n=0 mid-stream → all outputs 0, out_valid=0 on the next cycle. After release, a first accepted instruction appears 1 cycle later.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake bundle for the decode stage.
// Upstream side: in_valid/in_ready with inst and pc_in.
// Downstream side: out_valid/out_ready with the decoded fields.
// A transfer happens on a rising clock edge where valid and ready are both high.
// A producer holds valid and its payload stable until that edge.
// Ready may be high with nothing offered.
// master: the environment around the stage (fetch plus the consumer).
// slave: the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN           = 8,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int PC_WIDTH       = 8,
    parameter int INST_WIDTH     = 32
) ();
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [INST_WIDTH-1:0]     inst;
    logic [PC_WIDTH-1:0]       pc_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [6:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [XLEN-1:0]           imm;
    logic [2:0]                imm_fmt;
    logic                      illegal;
    logic [PC_WIDTH-1:0]       pc_out;
    logic [1:0]                state_dbg;

    modport master (
        output flush, in_valid, inst, pc_in, out_ready,
        input  in_ready, out_valid, op, rd, rs1, rs2, funct3, funct7,
               imm, imm_fmt, illegal, pc_out, state_dbg
    );

    modport slave (
        input  flush, in_valid, inst, pc_in, out_ready,
        output in_ready, out_valid, op, rd, rs1, rs2, funct3, funct7,
               imm, imm_fmt, illegal, pc_out, state_dbg
    );
endinterface

// File: rtl/decode_stage.sv
// RV32-style decode stage with a 2-entry skid buffer.
// Decode is combinational on inst and is captured at accept time.
// Every output comes from the main register or from the state flop.
// Buffer occupancy is EMPTY / ONE / TWO.
// in_ready depends only on occupancy, so there is no combinational path from out_ready.
// flush and reset both empty the stage.
// Reset additionally zeroes the held bundles.
module decode_stage #(
    parameter int XLEN           = 8,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int PC_WIDTH       = 8,
    parameter int INST_WIDTH     = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    if (INST_WIDTH != 32) begin : g_bad_inst_width
        $error("decode_stage: INST_WIDTH must be 32");
    end

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_R    = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [6:0]                op;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [2:0]                funct3;
        logic [6:0]                funct7;
        logic [XLEN-1:0]           imm;
        logic [2:0]                imm_fmt;
        logic                      illegal;
        logic [PC_WIDTH-1:0]       pc;
    } bundle_t;

    logic [31:0]     inst_w;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic [2:0]      fmt;
    logic            op_known;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            rd_hi;
    logic            rs1_hi;
    logic            rs2_hi;
    logic            bad_field;
    bundle_t         dec;

    state_e  state_q, state_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    accept;
    logic    in_ready_w;
    logic    out_valid_w;

    assign inst_w = bus.inst[31:0];

    // Select the format and build the sign-extended 32-bit immediate.
    // Also record which register fields this format actually reads or writes.
    always_comb begin
        imm32    = 32'd0;
        fmt      = FMT_NONE;
        op_known = 1'b1;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (inst_w[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt    = FMT_U;
                imm32  = {inst_w[31:12], 12'd0};
                use_rd = 1'b1;
            end
            OPC_JAL: begin
                fmt    = FMT_J;
                imm32  = {{11{inst_w[31]}}, inst_w[31], inst_w[19:12],
                          inst_w[20], inst_w[30:21], 1'b0};
                use_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                fmt     = FMT_I;
                imm32   = {{20{inst_w[31]}}, inst_w[31:20]};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                fmt     = FMT_S;
                imm32   = {{20{inst_w[31]}}, inst_w[31:25], inst_w[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                fmt     = FMT_B;
                imm32   = {{19{inst_w[31]}}, inst_w[31], inst_w[7],
                           inst_w[30:25], inst_w[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP: begin
                fmt     = FMT_R;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: begin
                op_known = 1'b0;
            end
        endcase
    end

    // Resize the RV32 immediate to XLEN: truncate when narrower, sign-extend when wider.
    if (XLEN < 32) begin : g_imm_narrow
        logic unused_imm_hi;
        assign imm_x         = imm32[XLEN-1:0];
        assign unused_imm_hi = ^imm32[31:XLEN];
    end else if (XLEN == 32) begin : g_imm_exact
        assign imm_x = imm32;
    end else begin : g_imm_wide
        assign imm_x = {{(XLEN-32){imm32[31]}}, imm32};
    end

    // A used register field must fit in REG_ADDR_WIDTH bits to be addressable.
    assign rd_hi     = (inst_w[11:7]  >> REG_ADDR_WIDTH) != 5'd0;
    assign rs1_hi    = (inst_w[19:15] >> REG_ADDR_WIDTH) != 5'd0;
    assign rs2_hi    = (inst_w[24:20] >> REG_ADDR_WIDTH) != 5'd0;
    assign bad_field = (use_rd && rd_hi) || (use_rs1 && rs1_hi) || (use_rs2 && rs2_hi);

    // Assemble the decoded bundle for the instruction on the input.
    // Illegal instructions keep every field populated so the consumer can trap on them.
    always_comb begin
        dec         = '0;
        dec.op      = inst_w[6:0];
        dec.rd      = REG_ADDR_WIDTH'(inst_w[11:7]);
        dec.rs1     = REG_ADDR_WIDTH'(inst_w[19:15]);
        dec.rs2     = REG_ADDR_WIDTH'(inst_w[24:20]);
        dec.funct3  = inst_w[14:12];
        dec.funct7  = inst_w[31:25];
        dec.imm     = imm_x;
        dec.imm_fmt = fmt;
        dec.illegal = !op_known || (inst_w[1:0] != 2'b11) || bad_field;
        dec.pc      = bus.pc_in;
    end

    assign in_ready_w  = (state_q != ST_TWO);
    assign out_valid_w = (state_q != ST_EMPTY);
    assign accept      = bus.in_valid && in_ready_w;

    // Occupancy transitions.
    // Flush empties the stage and drops any same-cycle input.
    // Otherwise new data lands in main, or in skid when main is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = dec;
                    end
                end
                ST_ONE: begin
                    if (accept && bus.out_ready) begin
                        main_d = dec;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = dec;
                    end else if (bus.out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (bus.out_ready) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and buffer registers.
    // Reset zeroes both bundles so the outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.op        = main_q.op;
    assign bus.rd        = main_q.rd;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.funct3    = main_q.funct3;
    assign bus.funct7    = main_q.funct7;
    assign bus.imm       = main_q.imm;
    assign bus.imm_fmt   = main_q.imm_fmt;
    assign bus.illegal   = main_q.illegal;
    assign bus.pc_out    = main_q.pc;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage.
// Two instances are driven with identical stimulus:
//   dut_a: XLEN=32, REG_ADDR_WIDTH=5
//   dut_b: XLEN=8,  REG_ADDR_WIDTH=4
// A table of hand-decoded instructions is streamed through both.
// Directed sequences then exercise backpressure, flush and mid-stream reset.
module tb_decode_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    decode_stage_if #(.XLEN(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(8), .INST_WIDTH(32)) ia ();
    decode_stage_if #(.XLEN(8),  .REG_ADDR_WIDTH(4), .PC_WIDTH(8), .INST_WIDTH(32)) ib ();

    decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(8), .INST_WIDTH(32)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    decode_stage #(.XLEN(8), .REG_ADDR_WIDTH(4), .PC_WIDTH(8), .INST_WIDTH(32)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  fmt;
        logic [31:0] imm_a;
        logic        ill_a;
        logic [4:0]  rd_a;
        logic [4:0]  rs1_a;
        logic [4:0]  rs2_a;
        logic [7:0]  imm_b;
        logic        ill_b;
        logic [3:0]  rd_b;
        logic [3:0]  rs1_b;
        logic [3:0]  rs2_b;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [7:0] pc);
        ia.in_valid = v;
        ib.in_valid = v;
        ia.inst     = inst;
        ib.inst     = inst;
        ia.pc_in    = pc;
        ib.pc_in    = pc;
    endtask

    task automatic set_ctl(input logic flush, input logic out_ready);
        ia.flush     = flush;
        ib.flush     = flush;
        ia.out_ready = out_ready;
        ib.out_ready = out_ready;
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, " valid"},  32'(ia.out_valid), 32'd0);
        chk({tag, " ready"},  32'(ia.in_ready),  32'd1);
        chk({tag, " op"},     32'(ia.op),        32'd0);
        chk({tag, " rd"},     32'(ia.rd),        32'd0);
        chk({tag, " rs1"},    32'(ia.rs1),       32'd0);
        chk({tag, " rs2"},    32'(ia.rs2),       32'd0);
        chk({tag, " funct3"}, 32'(ia.funct3),    32'd0);
        chk({tag, " funct7"}, 32'(ia.funct7),    32'd0);
        chk({tag, " imm"},    ia.imm,            32'd0);
        chk({tag, " fmt"},    32'(ia.imm_fmt),   32'd0);
        chk({tag, " ill"},    32'(ia.illegal),   32'd0);
        chk({tag, " pc"},     32'(ia.pc_out),    32'd0);
        chk({tag, " b_valid"}, 32'(ib.out_valid), 32'd0);
        chk({tag, " b_imm"},   32'(ib.imm),       32'd0);
    endtask

    // Scoreboard-free main sequence: every expected value comes from the table or is spelled out inline.
    initial begin
        logic [7:0] pc_e;
        string      s;

        n_checks = 0;
        n_fail   = 0;

        //          inst          op     f3    f7     fmt   imm_a          ill   rd     rs1    rs2    imm_b  ill   rd_b   rs1_b  rs2_b
        vecs[0]  = '{32'hFFF10093, 7'h13, 3'd0, 7'h7F, 3'd1, 32'hFFFFFFFF, 1'b0, 5'd1,  5'd2,  5'd31, 8'hFF, 1'b0, 4'd1,  4'd2,  4'd15};
        vecs[1]  = '{32'hFE000EE3, 7'h63, 3'd0, 7'h7F, 3'd3, 32'hFFFFFFFC, 1'b0, 5'd29, 5'd0,  5'd0,  8'hFC, 1'b0, 4'd13, 4'd0,  4'd0};
        vecs[2]  = '{32'h123450B7, 7'h37, 3'd5, 7'h09, 3'd4, 32'h12345000, 1'b0, 5'd1,  5'd8,  5'd3,  8'h00, 1'b0, 4'd1,  4'd8,  4'd3};
        vecs[3]  = '{32'h00000893, 7'h13, 3'd0, 7'h00, 3'd1, 32'h00000000, 1'b0, 5'd17, 5'd0,  5'd0,  8'h00, 1'b1, 4'd1,  4'd0,  4'd0};
        vecs[4]  = '{32'h0000000B, 7'h0B, 3'd0, 7'h00, 3'd0, 32'h00000000, 1'b1, 5'd0,  5'd0,  5'd0,  8'h00, 1'b1, 4'd0,  4'd0,  4'd0};
        vecs[5]  = '{32'h002081B3, 7'h33, 3'd0, 7'h00, 3'd6, 32'h00000000, 1'b0, 5'd3,  5'd1,  5'd2,  8'h00, 1'b0, 4'd3,  4'd1,  4'd2};
        vecs[6]  = '{32'h00000001, 7'h01, 3'd0, 7'h00, 3'd0, 32'h00000000, 1'b1, 5'd0,  5'd0,  5'd0,  8'h00, 1'b1, 4'd0,  4'd0,  4'd0};
        vecs[7]  = '{32'hFF412E23, 7'h23, 3'd2, 7'h7F, 3'd2, 32'hFFFFFFFC, 1'b0, 5'd28, 5'd2,  5'd20, 8'hFC, 1'b1, 4'd12, 4'd2,  4'd4};
        vecs[8]  = '{32'h001000EF, 7'h6F, 3'd0, 7'h00, 3'd5, 32'h00000800, 1'b0, 5'd1,  5'd0,  5'd1,  8'h00, 1'b0, 4'd1,  4'd0,  4'd1};
        vecs[9]  = '{32'hFFFFF117, 7'h17, 3'd7, 7'h7F, 3'd4, 32'hFFFFF000, 1'b0, 5'd2,  5'd31, 5'd31, 8'h00, 1'b0, 4'd2,  4'd15, 4'd15};
        vecs[10] = '{32'h004FA283, 7'h03, 3'd2, 7'h00, 3'd1, 32'h00000004, 1'b0, 5'd5,  5'd31, 5'd4,  8'h04, 1'b1, 4'd5,  4'd15, 4'd4};
        vecs[11] = '{32'h00008067, 7'h67, 3'd0, 7'h00, 3'd1, 32'h00000000, 1'b0, 5'd0,  5'd1,  5'd0,  8'h00, 1'b0, 4'd0,  4'd1,  4'd0};

        // Reset.
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 8'd0);
        set_ctl(1'b0, 1'b1);
        tick();
        tick();
        chk_zero_a("reset");
        chk("reset state", 32'(ia.state_dbg), 32'd0);
        rst_n = 1'b1;

        // Table: one instruction per cycle with out_ready=1.
        // Each bundle appears one cycle after its accept.
        for (int i = 0; i < 12; i++) begin
            pc_e = 8'h40 + 8'(i * 4);
            drive(1'b1, vecs[i].inst, pc_e);
            tick();
            s = $sformatf("v%0d", i);
            chk({s, " a_valid"}, 32'(ia.out_valid), 32'd1);
            chk({s, " a_pc"},    32'(ia.pc_out),    32'(pc_e));
            chk({s, " a_op"},    32'(ia.op),        32'(vecs[i].op));
            chk({s, " a_f3"},    32'(ia.funct3),    32'(vecs[i].f3));
            chk({s, " a_f7"},    32'(ia.funct7),    32'(vecs[i].f7));
            chk({s, " a_fmt"},   32'(ia.imm_fmt),   32'(vecs[i].fmt));
            chk({s, " a_imm"},   ia.imm,            vecs[i].imm_a);
            chk({s, " a_ill"},   32'(ia.illegal),   32'(vecs[i].ill_a));
            chk({s, " a_rd"},    32'(ia.rd),        32'(vecs[i].rd_a));
            chk({s, " a_rs1"},   32'(ia.rs1),       32'(vecs[i].rs1_a));
            chk({s, " a_rs2"},   32'(ia.rs2),       32'(vecs[i].rs2_a));
            chk({s, " b_imm"},   32'(ib.imm),       32'(vecs[i].imm_b));
            chk({s, " b_ill"},   32'(ib.illegal),   32'(vecs[i].ill_b));
            chk({s, " b_rd"},    32'(ib.rd),        32'(vecs[i].rd_b));
            chk({s, " b_rs1"},   32'(ib.rs1),       32'(vecs[i].rs1_b));
            chk({s, " b_rs2"},   32'(ib.rs2),       32'(vecs[i].rs2_b));
            chk({s, " b_fmt"},   32'(ib.imm_fmt),   32'(vecs[i].fmt));
        end
        drive(1'b0, 32'd0, 8'd0);
        tick();
        chk("drain valid", 32'(ia.out_valid), 32'd0);

        // Backpressure: A then B with out_ready=0 fills both entries.
        set_ctl(1'b0, 1'b0);
        drive(1'b1, vecs[0].inst, 8'h10);
        tick();
        chk("bp A valid", 32'(ia.out_valid), 32'd1);
        chk("bp A pc",    32'(ia.pc_out),    32'h10);
        chk("bp A ready", 32'(ia.in_ready),  32'd1);
        drive(1'b1, vecs[2].inst, 8'h14);
        tick();
        chk("bp two state", 32'(ia.state_dbg), 32'd2);
        chk("bp two ready", 32'(ia.in_ready),  32'd0);
        chk("bp two pc",    32'(ia.pc_out),    32'h10);
        // C is offered while full and must never be taken.
        drive(1'b1, vecs[5].inst, 8'h18);
        tick();
        chk("bp hold pc",    32'(ia.pc_out),  32'h10);
        chk("bp hold imm",   ia.imm,          32'hFFFFFFFF);
        chk("bp hold fmt",   32'(ia.imm_fmt), 32'd1);
        chk("bp hold ready", 32'(ia.in_ready), 32'd0);
        drive(1'b0, 32'd0, 8'd0);
        set_ctl(1'b0, 1'b1);
        tick();
        chk("bp B valid", 32'(ia.out_valid), 32'd1);
        chk("bp B pc",    32'(ia.pc_out),    32'h14);
        chk("bp B imm",   ia.imm,            32'h12345000);
        chk("bp B ready", 32'(ia.in_ready),  32'd1);
        chk("bp B b_pc",  32'(ib.pc_out),    32'h14);
        tick();
        chk("bp empty valid", 32'(ia.out_valid), 32'd0);

        // Flush while full, with a new instruction offered in the same cycle.
        set_ctl(1'b0, 1'b0);
        drive(1'b1, vecs[1].inst, 8'h20);
        tick();
        drive(1'b1, vecs[2].inst, 8'h24);
        tick();
        chk("fl pre state", 32'(ia.state_dbg), 32'd2);
        set_ctl(1'b1, 1'b0);
        drive(1'b1, vecs[5].inst, 8'h28);
        tick();
        chk("fl valid",   32'(ia.out_valid), 32'd0);
        chk("fl ready",   32'(ia.in_ready),  32'd1);
        chk("fl b_valid", 32'(ib.out_valid), 32'd0);
        set_ctl(1'b0, 1'b1);
        drive(1'b0, 32'd0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl quiet%0d", k), 32'(ia.out_valid), 32'd0);
        end

        // Stream, then reset mid-stream with flush also high.
        for (int k = 0; k < 5; k++) begin
            pc_e = 8'h80 + 8'(k * 4);
            drive(1'b1, vecs[k].inst, pc_e);
            tick();
            chk($sformatf("st%0d pc", k),    32'(ia.pc_out),    32'(pc_e));
            chk($sformatf("st%0d valid", k), 32'(ia.out_valid), 32'd1);
        end
        rst_n = 1'b0;
        set_ctl(1'b1, 1'b1);
        drive(1'b1, vecs[5].inst, 8'h94);
        tick();
        chk_zero_a("midrst");
        rst_n = 1'b1;
        set_ctl(1'b0, 1'b1);
        drive(1'b1, vecs[0].inst, 8'hA0);
        tick();
        chk("post valid", 32'(ia.out_valid), 32'd1);
        chk("post pc",    32'(ia.pc_out),    32'hA0);
        chk("post imm",   ia.imm,            32'hFFFFFFFF);
        drive(1'b0, 32'd0, 8'd0);
        tick();
        chk("post empty", 32'(ia.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
